// File: rtl/branch_update_sched.sv
// Branch update scheduler: queues resolved branches from writeback and serialises
// predictor and BTB updates. Optional statistics counters via BRANCH_UPDATE_STATS_EN.
module branch_update_sched (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [15:0] wb_pc,
  input  logic [15:0] wb_target,
  input  logic        wb_is_cond,
  input  logic        wb_take_jump,
  input  logic        wb_predict_taken,
  input  logic        wb_predictor,
  input  logic        btb_ready,
  output logic        full,
  output logic        update_branch_history,
  output logic [15:0] resolved_pc,
  output logic        upd_take_jump,
  output logic        upd_predict_taken,
  output logic        upd_predictor,
  output logic        btb_write,
  output logic [15:0] btb_pc,
  output logic [15:0] btb_target,
  output logic        overflow,
  output logic [15:0] mispredict_count,
  output logic [15:0] branch_count
);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
    logic        is_cond;
    logic        take_jump;
    logic        predict_taken;
    logic        predictor;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRED = 2'd1,
    BTB  = 2'd2
  } state_t;

  entry_t     queue_mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;
  state_t     state;
  state_t     next_state;
  entry_t     head;
  entry_t     wb_entry;
  logic       pop;
  logic       push;
  logic       queue_empty;

  assign head        = queue_mem[rd_ptr];
  assign queue_empty = (count == 3'd0);
  assign full        = (count == 3'd4);
  assign push        = wb_valid && (!full || pop);

  assign wb_entry.pc            = wb_pc;
  assign wb_entry.target        = wb_target;
  assign wb_entry.is_cond       = wb_is_cond;
  assign wb_entry.take_jump     = wb_take_jump;
  assign wb_entry.predict_taken = wb_predict_taken;
  assign wb_entry.predictor     = wb_predictor;

  // Entry storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr] <= wb_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (push && !pop) begin
        count <= count + 3'd1;
      end else if (pop && !push) begin
        count <= count - 3'd1;
      end
      if (wb_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Head stays put during PRED/BTB; pop happens only on the edge that leaves them
  always_comb begin
    next_state            = state;
    pop                   = 1'b0;
    update_branch_history = 1'b0;
    resolved_pc           = 16'h0000;
    upd_take_jump         = 1'b0;
    upd_predict_taken     = 1'b0;
    upd_predictor         = 1'b0;
    btb_write             = 1'b0;
    btb_pc                = 16'h0000;
    btb_target            = 16'h0000;
    case (state)
      IDLE: begin
        if (!queue_empty) begin
          next_state = head.is_cond ? PRED : BTB;
        end
      end
      PRED: begin
        update_branch_history = 1'b1;
        resolved_pc           = head.pc;
        upd_take_jump         = head.take_jump;
        upd_predict_taken     = head.predict_taken;
        upd_predictor         = head.predictor;
        if (head.take_jump) begin
          next_state = BTB;
        end else begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      BTB: begin
        btb_write  = 1'b1;
        btb_pc     = head.pc;
        btb_target = head.target;
        if (btb_ready) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef BRANCH_UPDATE_STATS_EN
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  // Saturating counters, updated once per retired (popped) entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt     <= 16'h0000;
      mispredict_cnt <= 16'h0000;
    end else if (pop) begin
      if (branch_cnt != 16'hFFFF) begin
        branch_cnt <= branch_cnt + 16'd1;
      end
      if ((head.take_jump != head.predict_taken) && (mispredict_cnt != 16'hFFFF)) begin
        mispredict_cnt <= mispredict_cnt + 16'd1;
      end
    end
  end

  assign branch_count     = branch_cnt;
  assign mispredict_count = mispredict_cnt;
`else
  assign branch_count     = 16'h0000;
  assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_update_sched.sv
// Directed self-checking bench for branch_update_sched.
module tb_branch_update_sched;

  logic        clk;
  logic        reset_n;
  logic        wb_valid;
  logic [15:0] wb_pc;
  logic [15:0] wb_target;
  logic        wb_is_cond;
  logic        wb_take_jump;
  logic        wb_predict_taken;
  logic        wb_predictor;
  logic        btb_ready;
  logic        full;
  logic        update_branch_history;
  logic [15:0] resolved_pc;
  logic        upd_take_jump;
  logic        upd_predict_taken;
  logic        upd_predictor;
  logic        btb_write;
  logic [15:0] btb_pc;
  logic [15:0] btb_target;
  logic        overflow;
  logic [15:0] mispredict_count;
  logic [15:0] branch_count;

  int checks;
  int errors;

  branch_update_sched dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .wb_valid              (wb_valid),
    .wb_pc                 (wb_pc),
    .wb_target             (wb_target),
    .wb_is_cond            (wb_is_cond),
    .wb_take_jump          (wb_take_jump),
    .wb_predict_taken      (wb_predict_taken),
    .wb_predictor          (wb_predictor),
    .btb_ready             (btb_ready),
    .full                  (full),
    .update_branch_history (update_branch_history),
    .resolved_pc           (resolved_pc),
    .upd_take_jump         (upd_take_jump),
    .upd_predict_taken     (upd_predict_taken),
    .upd_predictor         (upd_predictor),
    .btb_write             (btb_write),
    .btb_pc                (btb_pc),
    .btb_target            (btb_target),
    .overflow              (overflow),
    .mispredict_count      (mispredict_count),
    .branch_count          (branch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 ns after each rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] tgt, input logic is_cond,
                      input logic tj, input logic pt, input logic pr);
    wb_pc            = pc;
    wb_target        = tgt;
    wb_is_cond       = is_cond;
    wb_take_jump     = tj;
    wb_predict_taken = pt;
    wb_predictor     = pr;
    wb_valid         = 1'b1;
    tick();
    wb_valid         = 1'b0;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    wb_valid  = 1'b0;
    btb_ready = 1'b0;
    wb_pc = 16'h0; wb_target = 16'h0; wb_is_cond = 1'b0;
    wb_take_jump = 1'b0; wb_predict_taken = 1'b0; wb_predictor = 1'b0;
    repeat (2) tick();
    checks++;
    if ({full, update_branch_history, btb_write, overflow} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 0000", {full, update_branch_history, btb_write, overflow});
    end
    checks++;
    if ({resolved_pc, btb_pc, btb_target} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL reset_payload got %h want 0", {resolved_pc, btb_pc, btb_target});
    end
    checks++;
    if ({branch_count, mispredict_count} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_counters got %h want 0", {branch_count, mispredict_count});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_taken_br;
    btb_ready = 1'b1;
    push(16'h0040, 16'h0030, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({update_branch_history, btb_write} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL taken_cycle1 got %b want 00", {update_branch_history, btb_write});
    end
    tick();
    checks++;
    if ({update_branch_history, btb_write, resolved_pc, upd_take_jump, upd_predict_taken, upd_predictor}
        !== {2'b10, 16'h0040, 3'b110}) begin
      errors++;
      $display("[TB] FAIL taken_pred got uh=%b bw=%b pc=%h tj=%b pt=%b pr=%b want uh=1 bw=0 pc=0040 tj=1 pt=1 pr=0",
               update_branch_history, btb_write, resolved_pc, upd_take_jump, upd_predict_taken, upd_predictor);
    end
    tick();
    checks++;
    if ({update_branch_history, btb_write, btb_pc, btb_target} !== {2'b01, 16'h0040, 16'h0030}) begin
      errors++;
      $display("[TB] FAIL taken_btb got uh=%b bw=%b pc=%h tgt=%h want uh=0 bw=1 pc=0040 tgt=0030",
               update_branch_history, btb_write, btb_pc, btb_target);
    end
    tick();
    checks++;
    if ({update_branch_history, btb_write, full} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL taken_done got %b want 000", {update_branch_history, btb_write, full});
    end
    tick();
    checks++;
    if ({update_branch_history, btb_write} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL taken_empty got %b want 00", {update_branch_history, btb_write});
    end
  endtask

  task automatic test_not_taken;
    int pulses;
    int writes;
    logic [15:0] seen_pc;
    logic        seen_pr;
    pulses  = 0;
    writes  = 0;
    seen_pc = 16'h0;
    seen_pr = 1'b0;
    btb_ready = 1'b1;
    push(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (update_branch_history) begin
        pulses++;
        seen_pc = resolved_pc;
        seen_pr = upd_predictor;
      end
      if (btb_write) writes++;
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL nt_pulses got %0d want 1", pulses);
    end
    checks++;
    if (writes !== 0) begin
      errors++;
      $display("[TB] FAIL nt_btb_writes got %0d want 0", writes);
    end
    checks++;
    if ({seen_pc, seen_pr} !== {16'h0100, 1'b1}) begin
      errors++;
      $display("[TB] FAIL nt_payload got pc=%h pr=%b want pc=0100 pr=1", seen_pc, seen_pr);
    end
  endtask

  task automatic test_btb_stall;
    int n;
    int held;
    btb_ready = 1'b0;
    push(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!btb_write && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (btb_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_start got btb_write=%b want 1", btb_write);
    end
    held = 0;
    for (int i = 0; i < 6; i++) begin
      if (btb_write && !update_branch_history && btb_pc == 16'h1234 && btb_target == 16'h5678) held++;
      btb_ready = (i == 5);
      tick();
    end
    btb_ready = 1'b0;
    checks++;
    if (held !== 6) begin
      errors++;
      $display("[TB] FAIL stall_held got %0d want 6", held);
    end
    checks++;
    if (btb_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_pop got btb_write=%b want 0", btb_write);
    end
    repeat (2) tick();
  endtask

  task automatic test_overflow;
    int n;
    int got;
    logic [15:0] exp_pc;
    btb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 16'h0300 + 16'(i);
      push(exp_pc, exp_pc + 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if ({full, overflow} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ovf_full4 got full=%b ovf=%b want full=1 ovf=0", full, overflow);
    end
    push(16'h0399, 16'h0499, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({full, overflow} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ovf_drop got full=%b ovf=%b want 11", full, overflow);
    end
    btb_ready = 1'b1;
    got = 0;
    n = 0;
    while (n < 40) begin
      if (btb_write) begin
        exp_pc = 16'h0300 + 16'(got);
        checks++;
        if (btb_pc !== exp_pc || btb_target !== exp_pc + 16'h0100) begin
          errors++;
          $display("[TB] FAIL ovf_order got pc=%h tgt=%h want pc=%h tgt=%h",
                   btb_pc, btb_target, exp_pc, exp_pc + 16'h0100);
        end
        got++;
      end
      tick();
      n++;
    end
    checks++;
    if (got !== 4) begin
      errors++;
      $display("[TB] FAIL ovf_drain_count got %0d want 4", got);
    end
    checks++;
    if ({full, overflow} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ovf_sticky got full=%b ovf=%b want full=0 ovf=1", full, overflow);
    end
  endtask

  task automatic test_reset_mid_pred;
    int strobes;
    btb_ready = 1'b0;
    push(16'h0500, 16'h0600, 1'b0, 1'b1, 1'b1, 1'b0);
    push(16'h0510, 16'h0610, 1'b1, 1'b0, 1'b0, 1'b0);
    push(16'h0520, 16'h0620, 1'b1, 1'b0, 1'b0, 1'b0);
    push(16'h0530, 16'h0630, 1'b1, 1'b1, 1'b0, 1'b0);
    btb_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({update_branch_history, resolved_pc} !== {1'b1, 16'h0510}) begin
      errors++;
      $display("[TB] FAIL midpred_setup got uh=%b pc=%h want uh=1 pc=0510", update_branch_history, resolved_pc);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({full, update_branch_history, btb_write, overflow, upd_take_jump, upd_predict_taken, upd_predictor} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL midpred_flags got %b want 0000000",
               {full, update_branch_history, btb_write, overflow, upd_take_jump, upd_predict_taken, upd_predictor});
    end
    checks++;
    if ({resolved_pc, btb_pc, btb_target, branch_count, mispredict_count} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL midpred_payload got %h want 0",
               {resolved_pc, btb_pc, btb_target, branch_count, mispredict_count});
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({update_branch_history, btb_write} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midpred_first_cycle got %b want 00", {update_branch_history, btb_write});
    end
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      if (update_branch_history || btb_write) strobes++;
      tick();
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("[TB] FAIL midpred_queue_empty got %0d strobes want 0", strobes);
    end
  endtask

  task automatic test_stats;
    logic [15:0] exp_branch;
    logic [15:0] exp_mis;
    btb_ready = 1'b1;
    push(16'h0700, 16'h0710, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    push(16'h0720, 16'h0730, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    push(16'h0740, 16'h0750, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
`ifdef BRANCH_UPDATE_STATS_EN
    exp_branch = 16'd3;
    exp_mis    = 16'd1;
`else
    exp_branch = 16'd0;
    exp_mis    = 16'd0;
`endif
    checks++;
    if (branch_count !== exp_branch) begin
      errors++;
      $display("[TB] FAIL stats_branch got %0d want %0d", branch_count, exp_branch);
    end
    checks++;
    if (mispredict_count !== exp_mis) begin
      errors++;
      $display("[TB] FAIL stats_mispredict got %0d want %0d", mispredict_count, exp_mis);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_taken_br();
    test_not_taken();
    test_btb_stall();
    test_overflow();
    test_reset_mid_pred();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_update_sched.md
BRANCH_UPDATE_SCHED -- requirements
Module: branch_update_sched

Interface
REQ-001 SHALL have no parameters; queue depth is fixed at 4 entries and all PCs/targets are lc3b_word (16 bits).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 wb_valid  in  1  resolved branch (BR/JMP/JSR/TRAP) retiring this cycle.
REQ-005 wb_pc, wb_target  in  16 each  branch PC and resolved target.
REQ-006 wb_is_cond  in  1  1 = BR, 0 = unconditional.
REQ-007 wb_take_jump, wb_predict_taken, wb_predictor  in  1 each  actual outcome, prediction, and tournament source (0 = local, 1 = global).
REQ-008 btb_ready  in  1  BTB accepts a write this cycle.
REQ-009 full  out  1  queue holds 4 entries; the writeback stage stalls on it.
REQ-010 update_branch_history  out  1  one-cycle predictor/tournament update strobe.
REQ-011 resolved_pc, upd_take_jump, upd_predict_taken, upd_predictor  out  16/1/1/1  head-entry fields, valid while update_branch_history = 1.
REQ-012 btb_write, btb_pc, btb_target  out  1/16/16  BTB write request and payload.
REQ-013 overflow  out  1  sticky: a push was dropped.
REQ-014 mispredict_count, branch_count  out  16 each  statistics (see Configuration).

Function
REQ-015 Queue SHALL be a 4-entry FIFO with 2-bit read/write pointers, wrapping 3 -> 0, plus a 3-bit count.
- Entry fields: pc, target, is_cond, take_jump, predict_taken, predictor.
REQ-016 Push SHALL occur when wb_valid = 1 and (count < 4, or a pop occurs in the same cycle).
- Push and pop in the same cycle SHALL leave count unchanged.
REQ-017 A push with wb_valid = 1 while count = 4 and no same-cycle pop SHALL be dropped and SHALL set overflow, which holds until reset.
REQ-018 full SHALL equal (count == 4), combinationally from registered count.
REQ-019 FSM states: IDLE, PRED, BTB.
- IDLE: count > 0 and head is_cond -> PRED; count > 0 and head unconditional -> BTB.
REQ-020 PRED SHALL last exactly one cycle with update_branch_history = 1.
- Head take_jump = 1 -> BTB; else pop -> IDLE.
REQ-021 BTB SHALL hold btb_write = 1 with head pc/target until btb_ready = 1, then pop -> IDLE.
REQ-022 Outputs SHALL be Moore (decoded from state and head entry) with zero latency from state entry.
- Minimum service time: 2 cycles per entry (IDLE + PRED or BTB), 3 cycles for a taken BR.
REQ-023 The head entry SHALL NOT change while the FSM is in PRED or BTB; the pop occurs on the exit edge.
REQ-024 update_branch_history and btb_write SHALL never be 1 in the same cycle.
REQ-025 Entries SHALL be serviced strictly in push order.

Reset
REQ-026 reset_n = 0 SHALL immediately and asynchronously:
- set state to IDLE;
- clear pointers, count, overflow and counters;
- drive full, update_branch_history and btb_write to 0;
- drive all payload outputs to 0.
REQ-027 Reset asserted mid-PRED or mid-BTB SHALL discard all queued entries; no strobe SHALL occur in the first cycle after release.

Configuration
REQ-028 Macro BRANCH_UPDATE_STATS_EN.
- Defined: branch_count SHALL increment once per pop.
- Defined: mispredict_count SHALL increment once per pop where take_jump != predict_taken.
- Defined: both counters SHALL saturate at 16'hFFFF.
- Undefined: both outputs SHALL be tied to 0 and no counter registers SHALL exist.

Verification
REQ-029 After reset, push a taken BR (pc = 16'h0040, target = 16'h0030), btb_ready = 1.
- Response: update_branch_history on cycle +2, btb_write with 16'h0040/16'h0030 on cycle +3, then queue empty.
REQ-030 Push a not-taken BR.
- Response: exactly one update_branch_history pulse, no btb_write.
REQ-031 Push a JMP with btb_ready held 0 for 5 cycles.
- Response: btb_write held for 6 cycles with stable payload, pop on the 6th.
REQ-032 Hold btb_ready = 0 and push 5 entries.
- Response: full = 1 after the 4th push; the 5th is dropped and overflow = 1.
- Release btb_ready: 4 entries drain in order.
REQ-033 Assert reset_n = 0 during PRED with 3 entries queued.
- Response: all outputs immediately 0 and count = 0.
REQ-034 With BRANCH_UPDATE_STATS_EN defined, retire 3 branches, 1 of them mispredicted.
- Response: branch_count = 3, mispredict_count = 1.
